// File: rtl/dual_port_ram.sv
// Simple dual-port register-file RAM.
// One synchronous write port and one combinational read port on a single clock.
// The read path has no register, so a FIFO built on top can register its own output.
// The storage is a plain array, so synthesis maps it to distributed/LUT RAM or flops.
module dual_port_ram #(
    parameter int ASIZE = 3,
    parameter int DSIZE = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_we,
    input  logic [ASIZE-1:0] i_wr_addr,
    input  logic [ASIZE-1:0] i_rd_addr,
    input  logic [DSIZE-1:0] i_data,
    output logic [DSIZE-1:0] o_data
);

    localparam int DEPTH = 1 << ASIZE;

    logic [DSIZE-1:0] mem_q [DEPTH];

    // Clear every entry on reset; reset outranks a write in the same cycle.
    // Otherwise store the write word at the write address only.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (i_we) begin
            mem_q[i_wr_addr] <= i_data;
        end
    end

    // Read-before-write: a colliding write becomes visible only after the edge.
    assign o_data = mem_q[i_rd_addr];

endmodule

// File: tb/tb_dual_port_ram.sv
// Directed bench for dual_port_ram: a default 8x32 instance and a 4x8 instance.
module tb_dual_port_ram;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [2:0]  wr_addr;
    logic [2:0]  rd_addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    logic        s_rst_n;
    logic        s_we;
    logic [1:0]  s_wr_addr;
    logic [1:0]  s_rd_addr;
    logic [7:0]  s_wdata;
    logic [7:0]  s_rdata;

    int checks = 0;
    int errors = 0;

    dual_port_ram #(3, 32) u_dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_we      (we),
        .i_wr_addr (wr_addr),
        .i_rd_addr (rd_addr),
        .i_data    (wdata),
        .o_data    (rdata)
    );

    dual_port_ram #(.ASIZE(2), .DSIZE(8)) u_small (
        .i_clk     (clk),
        .i_rst_n   (s_rst_n),
        .i_we      (s_we),
        .i_wr_addr (s_wr_addr),
        .i_rd_addr (s_rd_addr),
        .i_data    (s_wdata),
        .o_data    (s_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst_n;
        logic        we;
        logic [2:0]  wr_addr;
        logic [31:0] data;
        logic [2:0]  rd_addr;
        logic [31:0] exp_before;
        logic [31:0] exp_after;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end else begin
            $display("ok   %s: %08h", name, got);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, far from the next one.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{"coll_prep",  1'b1, 1'b1, 3'd5, 32'hAAAA_AAAA, 3'd5, 32'h1000_0005, 32'hAAAA_AAAA};
        vecs[1]  = '{"collision",  1'b1, 1'b1, 3'd5, 32'h5555_5555, 3'd5, 32'hAAAA_AAAA, 32'h5555_5555};
        vecs[2]  = '{"we_low_0",   1'b1, 1'b0, 3'd3, 32'hFFFF_FFFF, 3'd3, 32'h1000_0003, 32'h1000_0003};
        vecs[3]  = '{"we_low_1",   1'b1, 1'b0, 3'd3, 32'hFFFF_FFFF, 3'd3, 32'h1000_0003, 32'h1000_0003};
        vecs[4]  = '{"we_low_2",   1'b1, 1'b0, 3'd3, 32'hFFFF_FFFF, 3'd3, 32'h1000_0003, 32'h1000_0003};
        vecs[5]  = '{"other_addr", 1'b1, 1'b1, 3'd6, 32'h0000_0066, 3'd5, 32'h5555_5555, 32'h5555_5555};
        vecs[6]  = '{"addr6_new",  1'b1, 1'b0, 3'd0, 32'h0000_0000, 3'd6, 32'h0000_0066, 32'h0000_0066};
        vecs[7]  = '{"b2b_first",  1'b1, 1'b1, 3'd1, 32'h0000_0001, 3'd1, 32'h1000_0001, 32'h0000_0001};
        vecs[8]  = '{"b2b_last",   1'b1, 1'b1, 3'd1, 32'h0000_0002, 3'd1, 32'h0000_0001, 32'h0000_0002};
        vecs[9]  = '{"addr4_keep", 1'b1, 1'b0, 3'd1, 32'h0000_0000, 3'd4, 32'h1000_0004, 32'h1000_0004};
        vecs[10] = '{"rst_drop_w", 1'b0, 1'b1, 3'd7, 32'h1234_5678, 3'd7, 32'h1000_0007, 32'h0000_0000};
        vecs[11] = '{"rst_clr_5",  1'b1, 1'b0, 3'd0, 32'h0000_0000, 3'd5, 32'h0000_0000, 32'h0000_0000};

        rst_n = 1'b0; we = 1'b1; wr_addr = 3'd2; rd_addr = 3'd0; wdata = 32'hDEAD_BEEF;
        s_rst_n = 1'b0; s_we = 1'b0; s_wr_addr = 2'd0; s_rd_addr = 2'd0; s_wdata = 8'h00;

        // Reset edge with a write pending: the write must be dropped.
        tick();
        rst_n = 1'b1; we = 1'b0; s_rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            rd_addr = 3'(k);
            #1;
            check($sformatf("reset_rd%0d", k), rdata, 32'h0);
        end

        // Fill, then sweep the read address with no clock edge in between.
        for (int k = 0; k < 8; k++) begin
            we = 1'b1; wr_addr = 3'(k); wdata = 32'h1000_0000 + 32'(k);
            tick();
        end
        we = 1'b0;
        for (int k = 0; k < 8; k++) begin
            rd_addr = 3'(k);
            #1;
            check($sformatf("fill_rd%0d", k), rdata, 32'h1000_0000 + 32'(k));
        end

        // Table: each record is checked before and after one rising edge.
        for (int v = 0; v < 12; v++) begin
            rst_n = vecs[v].rst_n; we = vecs[v].we; wr_addr = vecs[v].wr_addr;
            wdata = vecs[v].data; rd_addr = vecs[v].rd_addr;
            #1;
            check({vecs[v].name, "_pre"}, rdata, vecs[v].exp_before);
            tick();
            check({vecs[v].name, "_post"}, rdata, vecs[v].exp_after);
        end
        rst_n = 1'b1; we = 1'b0;

        // After the mid-run reset, everything reads zero.
        for (int k = 0; k < 8; k++) begin
            rd_addr = 3'(k);
            #1;
            check($sformatf("midrst_rd%0d", k), rdata, 32'h0);
        end

        // A single write after reset leaves only that entry nonzero.
        we = 1'b1; wr_addr = 3'd7; wdata = 32'h0000_0077;
        tick();
        we = 1'b0;
        for (int k = 0; k < 8; k++) begin
            rd_addr = 3'(k);
            #1;
            check($sformatf("only7_rd%0d", k), rdata, (k == 7) ? 32'h0000_0077 : 32'h0);
        end

        // Narrow instance: four entries 0x11..0x44.
        for (int k = 0; k < 4; k++) begin
            s_we = 1'b1; s_wr_addr = 2'(k); s_wdata = 8'(8'h11 * (k + 1));
            tick();
        end
        s_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s_rd_addr = 2'(k);
            #1;
            check($sformatf("small_rd%0d", k), 32'(s_rdata), 32'(8'h11 * (k + 1)));
        end

        // Top index followed by index 0: plain indices, no wrap side effects.
        s_we = 1'b1; s_wr_addr = 2'd3; s_wdata = 8'h99;
        tick();
        s_wr_addr = 2'd0; s_wdata = 8'hAB;
        tick();
        s_we = 1'b0;
        s_rd_addr = 2'd3; #1; check("small_top", 32'(s_rdata), 32'h99);
        s_rd_addr = 2'd0; #1; check("small_zero", 32'(s_rdata), 32'hAB);
        s_rd_addr = 2'd1; #1; check("small_keep1", 32'(s_rdata), 32'h22);
        s_rd_addr = 2'd2; #1; check("small_keep2", 32'(s_rdata), 32'h33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
